// File: rtl/gift_key_sched_seq_if.sv
// Handshake bundle between the master-key source, the GIFT-128 key schedule
// and the round datapath that consumes its round keys.
interface gift_key_sched_seq_if;
  logic [127:0] keyIn;
  logic         keyValid;
  logic         keyReady;
  logic         abort;
  logic [31:0]  rkU;
  logic [31:0]  rkV;
  logic [5:0]   rc;
  logic [5:0]   roundIdx;
  logic         rkValid;
  logic         rkReady;
  logic         rkLast;
  logic         done;

  modport master (
    output keyIn, keyValid, abort, rkReady,
    input  keyReady, rkU, rkV, rc, roundIdx, rkValid, rkLast, done
  );

  modport slave (
    input  keyIn, keyValid, abort, rkReady,
    output keyReady, rkU, rkV, rc, roundIdx, rkValid, rkLast, done
  );
endinterface

// File: rtl/gift_key_sched_seq.sv
// Sequential GIFT-128 key schedule: loads a master key and streams one
// 64-bit round key plus 6-bit round constant per handshake.
module gift_key_sched_seq #(
  parameter int unsigned ROUNDS = 40
) (
  input logic                 clk,
  input logic                 rstN,
  gift_key_sched_seq_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [5:0] LastIdx = 6'(ROUNDS - 1);

  state_e       st_q, st_d;
  logic [127:0] key_q, key_d;
  logic [5:0]   rc_q, rc_d;
  logic [5:0]   idx_q, idx_d;
  logic         last_q, last_d;
  logic         done_q, done_d;

  // k7..k0 <- (k1>>>2) || (k0>>>12) || k7..k2, rotations within 16-bit words
  function automatic logic [127:0] key_update(input logic [127:0] s);
    return {s[17:16], s[31:18], s[11:0], s[15:12], s[127:32]};
  endfunction

  always_comb begin
    st_d   = st_q;
    key_d  = key_q;
    rc_d   = rc_q;
    idx_d  = idx_q;
    last_d = last_q;
    done_d = 1'b0;

    case (st_q)
      StIdle: begin
        // abort has no effect here, so a simultaneous load is still taken
        if (bus.keyValid) begin
          key_d  = bus.keyIn;
          rc_d   = 6'h01;
          idx_d  = 6'd0;
          last_d = (LastIdx == 6'd0);
          st_d   = StRun;
        end
      end
      StRun: begin
        if (bus.abort) begin
          st_d   = StIdle;
          last_d = 1'b0;
        end else if (bus.rkReady) begin
          if (idx_q == LastIdx) begin
            st_d   = StIdle;
            last_d = 1'b0;
            done_d = 1'b1;
          end else begin
            key_d  = key_update(key_q);
            rc_d   = {rc_q[4:0], rc_q[5] ^ rc_q[4] ^ 1'b1};
            idx_d  = idx_q + 6'd1;
            last_d = ((idx_q + 6'd1) == LastIdx);
          end
        end
      end
      default: begin
        st_d   = StIdle;
        last_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      st_q   <= StIdle;
      key_q  <= '0;
      rc_q   <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      key_q  <= key_d;
      rc_q   <= rc_d;
      idx_q  <= idx_d;
      last_q <= last_d;
      done_q <= done_d;
    end
  end

  assign bus.keyReady = (st_q == StIdle);
  assign bus.rkValid  = (st_q == StRun);
  assign bus.rkU      = key_q[95:64];
  assign bus.rkV      = key_q[31:0];
  assign bus.rc       = rc_q;
  assign bus.roundIdx = idx_q;
  assign bus.rkLast   = last_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_gift_key_sched_seq.sv
// Scoreboard bench for the GIFT-128 key schedule: a ROUNDS=40 instance for the
// main scenarios and a ROUNDS=1 instance for the single-round corner.
module tb_gift_key_sched_seq;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  gift_key_sched_seq_if a_if ();
  gift_key_sched_seq_if b_if ();

  gift_key_sched_seq #(.ROUNDS(40)) dut_a (.clk(clk), .rstN(rstN), .bus(a_if));
  gift_key_sched_seq #(.ROUNDS(1))  dut_b (.clk(clk), .rstN(rstN), .bus(b_if));

  typedef struct packed {
    logic [31:0] u;
    logic [31:0] v;
    logic [5:0]  rc;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] obs_u[$];
  logic [31:0] obs_v[$];
  logic [5:0]  obs_rc[$];
  int          errors = 0;
  int          checks = 0;

  localparam logic [127:0] Key3 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word-level software model of the GIFT-128 key update
  function automatic logic [127:0] model_next(input logic [127:0] s);
    logic [15:0]  k[8];
    logic [15:0]  n[8];
    logic [127:0] r;
    for (int i = 0; i < 8; i++) k[i] = s[16*i +: 16];
    n[7] = (k[1] >> 2) | (k[1] << 14);
    n[6] = (k[0] >> 12) | (k[0] << 4);
    for (int i = 0; i < 6; i++) n[i] = k[i+2];
    for (int i = 0; i < 8; i++) r[16*i +: 16] = n[i];
    return r;
  endfunction

  function automatic logic [5:0] model_rc(input logic [5:0] c);
    return (c << 1) | {5'b0, ~(c[5] ^ c[4])};
  endfunction

  task automatic push_run(input logic [127:0] key, input int rounds);
    logic [127:0] s;
    logic [5:0]   c;
    exp_t         e;
    s = key;
    c = 6'h01;
    for (int i = 0; i < rounds; i++) begin
      e.u    = s[95:64];
      e.v    = s[31:0];
      e.rc   = c;
      e.idx  = 6'(i);
      e.last = (i == rounds - 1);
      sb.push_back(e);
      s = model_next(s);
      c = model_rc(c);
    end
  endtask

  task automatic clear_obs();
    obs_u.delete();
    obs_v.delete();
    obs_rc.delete();
  endtask

  task automatic load_a(input logic [127:0] key);
    a_if.keyIn    = key;
    a_if.keyValid = 1'b1;
    chk("keyReady_idle", a_if.keyReady, 1);
    push_run(key, 40);
    tick();
    a_if.keyValid = 1'b0;
    chk("load_idx0", a_if.roundIdx, 0);
    chk("load_rc01", a_if.rc, 6'h01);
  endtask

  task automatic chk_reset_a();
    chk("rst_keyReady", a_if.keyReady, 1);
    chk("rst_rkValid", a_if.rkValid, 0);
    chk("rst_rkLast", a_if.rkLast, 0);
    chk("rst_done", a_if.done, 0);
    chk("rst_rc", a_if.rc, 0);
    chk("rst_roundIdx", a_if.roundIdx, 0);
    chk("rst_rkU", a_if.rkU, 0);
    chk("rst_rkV", a_if.rkV, 0);
  endtask

  task automatic consume_a(input bit stall, input int abort_at, input int rst_at);
    int   cyc = 0;
    bit   fin = 1'b0;
    exp_t h;
    while (!fin && cyc < 1000) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
        fin = 1'b1;
      end else begin
        h = sb[0];
        chk("rkValid", a_if.rkValid, 1);
        chk("keyReady_run", a_if.keyReady, 0);
        chk("rkU", a_if.rkU, h.u);
        chk("rkV", a_if.rkV, h.v);
        chk("rc", a_if.rc, h.rc);
        chk("roundIdx", a_if.roundIdx, h.idx);
        chk("rkLast", a_if.rkLast, h.last);
        chk("done_run", a_if.done, 0);
        if (abort_at == int'(h.idx)) begin
          a_if.abort   = 1'b1;
          a_if.rkReady = 1'b1;
          tick();
          a_if.abort   = 1'b0;
          a_if.rkReady = 1'b0;
          chk("abort_rkValid", a_if.rkValid, 0);
          chk("abort_keyReady", a_if.keyReady, 1);
          chk("abort_no_done", a_if.done, 0);
          tick();
          chk("abort_no_done2", a_if.done, 0);
          sb.delete();
          fin = 1'b1;
        end else if (rst_at == int'(h.idx)) begin
          rstN         = 1'b0;
          a_if.rkReady = 1'b1;
          tick();
          a_if.keyValid = 1'b0;
          a_if.rkReady  = 1'b0;
          rstN          = 1'b1;
          chk_reset_a();
          sb.delete();
          fin = 1'b1;
        end else begin
          a_if.rkReady = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (a_if.rkReady) begin
            obs_u.push_back(a_if.rkU);
            obs_v.push_back(a_if.rkV);
            obs_rc.push_back(a_if.rc);
          end
          tick();
          cyc++;
          if (a_if.rkReady) begin
            void'(sb.pop_front());
            if (h.last) begin
              fin = 1'b1;
              chk("done_pulse", a_if.done, 1);
              chk("end_rkValid", a_if.rkValid, 0);
              chk("end_keyReady", a_if.keyReady, 1);
              a_if.rkReady = 1'b0;
              tick();
              chk("done_once", a_if.done, 0);
            end
          end
        end
      end
    end
    if (!fin) chk("consume_timeout", 0, 1);
  endtask

  initial begin
    logic [5:0]   rc_tab[7];
    logic [127:0] kb;
    logic [127:0] kb2;
    rc_tab = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D};

    rstN = 1'b0;
    a_if.keyIn = '0; a_if.keyValid = 1'b0; a_if.abort = 1'b0; a_if.rkReady = 1'b0;
    b_if.keyIn = '0; b_if.keyValid = 1'b0; b_if.abort = 1'b0; b_if.rkReady = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    tick();
    chk_reset_a();
    chk("b_rst_keyReady", b_if.keyReady, 1);
    chk("b_rst_rkValid", b_if.rkValid, 0);

    // All-zero key, consumer always ready
    clear_obs();
    load_a('0);
    consume_a(1'b0, -1, -1);
    chk("t1_count", obs_rc.size(), 40);
    for (int i = 0; i < 7; i++) chk("t1_rc_seq", obs_rc[i], rc_tab[i]);
    chk("t1_rkU_zero", obs_u[39], 0);

    // Single bit in k1 walking through the schedule
    clear_obs();
    load_a(128'h0000_0000_0000_0000_0000_0000_0004_0000);
    consume_a(1'b0, -1, -1);
    chk("t2_r0_rkV", obs_v[0], 32'h0004_0000);
    chk("t2_r0_rkU", obs_u[0], 0);
    chk("t2_r1_rkU", obs_u[1], 0);
    chk("t2_r1_rkV", obs_v[1], 0);
    chk("t2_r2_rkU", obs_u[2], 32'h0001_0000);

    // Reference key with random back-pressure
    clear_obs();
    load_a(Key3);
    consume_a(1'b1, -1, -1);
    chk("t3_count", obs_rc.size(), 40);

    // Abort mid-run, then reload with abort still high in IDLE
    load_a(Key3);
    consume_a(1'b0, 10, -1);
    a_if.abort = 1'b1;
    load_a(Key3);
    a_if.abort = 1'b0;
    consume_a(1'b0, -1, -1);

    // Reset mid-run while keyValid offers a different key throughout
    load_a(~Key3);
    a_if.keyIn    = Key3;
    a_if.keyValid = 1'b1;
    consume_a(1'b0, -1, 20);
    tick();
    chk("t5_post_rst_idle", a_if.rkValid, 0);

    // ROUNDS=1 instance, second key loaded in the done cycle
    kb  = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
    kb2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    b_if.keyIn    = kb;
    b_if.keyValid = 1'b1;
    tick();
    b_if.keyValid = 1'b0;
    chk("b_rkValid", b_if.rkValid, 1);
    chk("b_rkLast", b_if.rkLast, 1);
    chk("b_idx", b_if.roundIdx, 0);
    chk("b_rkU", b_if.rkU, kb[95:64]);
    chk("b_rkV", b_if.rkV, kb[31:0]);
    chk("b_rc", b_if.rc, 6'h01);
    b_if.rkReady = 1'b1;
    tick();
    chk("b_done", b_if.done, 1);
    chk("b_idle_valid", b_if.rkValid, 0);
    chk("b_done_keyReady", b_if.keyReady, 1);
    b_if.keyIn    = kb2;
    b_if.keyValid = 1'b1;
    tick();
    b_if.keyValid = 1'b0;
    chk("b2_rkValid", b_if.rkValid, 1);
    chk("b2_rkU", b_if.rkU, kb2[95:64]);
    chk("b2_rkV", b_if.rkV, kb2[31:0]);
    chk("b2_rkLast", b_if.rkLast, 1);
    chk("b2_no_done", b_if.done, 0);
    tick();
    chk("b2_done", b_if.done, 1);
    b_if.rkReady = 1'b0;
    tick();
    chk("b2_done_once", b_if.done, 0);
    chk("b2_idle", b_if.rkValid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
